// File: rtl/rvga_types.sv
// rtl/rvga_types.sv - shared types for the writeback stage: register index, load ops, FSM states.
package rvga_types;

  typedef logic [4:0] rvga_reg_t;

  typedef enum logic [2:0] {
    LDOP_LB  = 3'd0,
    LDOP_LH  = 3'd1,
    LDOP_LW  = 3'd2,
    LDOP_LBU = 3'd3,
    LDOP_LHU = 3'd4
  } rvga_ldop_e;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

  typedef struct packed {
    rvga_reg_t  rd;
    logic       rd_w_v;
    rvga_ldop_e ldop;
    logic [1:0] addr_lo;
  } ld_req_s;

  // The wait counter only needs to reach timeout-1 before the timeout fires.
  function automatic int timeout_cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - upstream, data-memory response and register-file write signals.
interface writeback_stage_if #(
  parameter int width_p = 32
);

  logic                     mem_writeback_v;
  logic                     mem_writeback_ready;
  rvga_types::rvga_reg_t    mem_writeback_rd;
  logic                     mem_writeback_rd_w_v;
  logic [width_p-1:0]       mem_writeback_alu_data;
  logic                     mem_writeback_ld_v;
  rvga_types::rvga_ldop_e   mem_writeback_ldop;
  logic [1:0]               mem_writeback_addr_lo;
  logic                     dmem_resp_v;
  logic [width_p-1:0]       dmem_resp_data;
  logic                     writeback_rfetch_rd_w_v;
  rvga_types::rvga_reg_t    writeback_rfetch_rd;
  logic [width_p-1:0]       writeback_rfetch_rd_data;
  logic [63:0]              writeback_instret;
  logic                     writeback_err;

  modport master (
    output mem_writeback_v, mem_writeback_rd, mem_writeback_rd_w_v, mem_writeback_alu_data,
           mem_writeback_ld_v, mem_writeback_ldop, mem_writeback_addr_lo,
           dmem_resp_v, dmem_resp_data,
    input  mem_writeback_ready, writeback_rfetch_rd_w_v, writeback_rfetch_rd,
           writeback_rfetch_rd_data, writeback_instret, writeback_err
  );

  modport slave (
    input  mem_writeback_v, mem_writeback_rd, mem_writeback_rd_w_v, mem_writeback_alu_data,
           mem_writeback_ld_v, mem_writeback_ldop, mem_writeback_addr_lo,
           dmem_resp_v, dmem_resp_data,
    output mem_writeback_ready, writeback_rfetch_rd_w_v, writeback_rfetch_rd,
           writeback_rfetch_rd_data, writeback_instret, writeback_err
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// rtl/writeback_stage_load_align.sv - extracts and extends load data from an aligned memory word.
module load_align
  import rvga_types::*;
#(
  parameter int width_p = 32
) (
  input  rvga_ldop_e         ldop,
  input  logic [1:0]         addr_lo,
  input  logic [width_p-1:0] word_data,
  output logic [width_p-1:0] ld_data,
  output logic               misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_data[7:0];
    case (addr_lo)
      2'd1:    byte_sel = word_data[15:8];
      2'd2:    byte_sel = word_data[23:16];
      2'd3:    byte_sel = word_data[31:24];
      default: byte_sel = word_data[7:0];
    endcase
    half_sel = addr_lo[1] ? word_data[31:16] : word_data[15:0];
  end

  always_comb begin
    ld_data    = '0;
    misaligned = 1'b0;
    case (ldop)
      LDOP_LB:  ld_data = {{(width_p-8){byte_sel[7]}}, byte_sel};
      LDOP_LBU: ld_data = {{(width_p-8){1'b0}}, byte_sel};
      LDOP_LH: begin
        ld_data    = {{(width_p-16){half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LDOP_LHU: begin
        ld_data    = {{(width_p-16){1'b0}}, half_sel};
        misaligned = addr_lo[0];
      end
      LDOP_LW: begin
        ld_data    = word_data;
        misaligned = (addr_lo != 2'd0);
      end
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - retires ALU results and loads into the register file, tracks instret and errors.
module writeback_stage
  import rvga_types::*;
#(
  parameter int width_p   = 32,
  parameter int timeout_p = 255
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave wb
);

  localparam int                  cnt_w_lp    = timeout_cnt_width(timeout_p);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(timeout_p - 1);

  wb_state_e state, state_n;
  ld_req_s   ld_req;
  logic [cnt_w_lp-1:0] wait_cnt;

  logic ready, accept_alu, accept_ld, ld_resp, timeout_hit, spurious;
  logic retire, wr_en, err_set, misaligned;
  rvga_reg_t          wr_rd;
  logic [width_p-1:0] wr_data, ld_data;

  logic               rd_w_v_q;
  rvga_reg_t          rd_q;
  logic [width_p-1:0] rd_data_q;
  logic [63:0]        instret_q;
  logic               err_q;

  load_align #(.width_p(width_p)) u_load_align (
    .ldop       (ld_req.ldop),
    .addr_lo    (ld_req.addr_lo),
    .word_data  (wb.dmem_resp_data),
    .ld_data    (ld_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WB_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WB_IDLE:    if (accept_ld) state_n = WB_WAIT_LD;
      WB_WAIT_LD: if (ld_resp || timeout_hit) state_n = WB_IDLE;
      default:    state_n = WB_IDLE;
    endcase
  end

  always_comb begin
    ready       = (state == WB_IDLE);
    accept_alu  = wb.mem_writeback_v & ready & ~wb.mem_writeback_ld_v;
    accept_ld   = wb.mem_writeback_v & ready & wb.mem_writeback_ld_v;
    ld_resp     = (state == WB_WAIT_LD) & wb.dmem_resp_v;
    timeout_hit = (state == WB_WAIT_LD) & ~wb.dmem_resp_v & (wait_cnt == cnt_last_lp);
    // A response while idle, including the load's own accept cycle, has no owner.
    spurious    = ready & wb.dmem_resp_v;
    retire      = accept_alu | ld_resp;
    err_set     = spurious | timeout_hit | (ld_resp & misaligned);
    if (accept_alu) begin
      wr_en   = wb.mem_writeback_rd_w_v & (wb.mem_writeback_rd != 5'd0);
      wr_rd   = wb.mem_writeback_rd;
      wr_data = wb.mem_writeback_alu_data;
    end else begin
      wr_en   = ld_resp & ld_req.rd_w_v & (ld_req.rd != 5'd0) & ~misaligned;
      wr_rd   = ld_req.rd;
      wr_data = ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_w_v_q  <= 1'b0;
      rd_q      <= '0;
      rd_data_q <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      ld_req    <= '0;
    end else begin
      rd_w_v_q <= wr_en;
      if (wr_en) begin
        rd_q      <= wr_rd;
        rd_data_q <= wr_data;
      end
      if (retire)  instret_q <= instret_q + 64'd1;
      if (err_set) err_q     <= 1'b1;
      if (accept_ld) begin
        ld_req.rd      <= wb.mem_writeback_rd;
        ld_req.rd_w_v  <= wb.mem_writeback_rd_w_v;
        ld_req.ldop    <= wb.mem_writeback_ldop;
        ld_req.addr_lo <= wb.mem_writeback_addr_lo;
        wait_cnt       <= '0;
      end else if (state == WB_WAIT_LD && !wb.dmem_resp_v) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign wb.mem_writeback_ready      = ready;
  assign wb.writeback_rfetch_rd_w_v  = rd_w_v_q;
  assign wb.writeback_rfetch_rd      = rd_q;
  assign wb.writeback_rfetch_rd_data = rd_data_q;
  assign wb.writeback_instret        = instret_q;
  assign wb.writeback_err            = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized transaction-level checking of writeback_stage.
module tb_writeback_stage;
  import rvga_types::*;

  localparam int width_p   = 32;
  localparam int timeout_p = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_stage_if #(.width_p(width_p)) wb();

  writeback_stage #(.width_p(width_p), .timeout_p(timeout_p)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int ready_low_cnt = 0;

  logic        exp_ready   = 1'b1;
  logic        exp_w       = 1'b0;
  logic [4:0]  exp_rd      = '0;
  logic [31:0] exp_data    = '0;
  logic [63:0] exp_instret = '0;
  logic        exp_err     = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check64("ready",   64'(wb.mem_writeback_ready),      64'(exp_ready));
      check64("rd_w_v",  64'(wb.writeback_rfetch_rd_w_v),  64'(exp_w));
      check64("rd",      64'(wb.writeback_rfetch_rd),      64'(exp_rd));
      check64("rd_data", 64'(wb.writeback_rfetch_rd_data), 64'(exp_data));
      check64("instret", wb.writeback_instret,             exp_instret);
      check64("err",     64'(wb.writeback_err),            64'(exp_err));
      if (!wb.mem_writeback_ready) ready_low_cnt++;
    end
  end

  function automatic logic [31:0] model_fmt(input rvga_ldop_e op, input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * a[1]));
    case (op)
      LDOP_LB:  return 32'($signed(b));
      LDOP_LBU: return 32'(b);
      LDOP_LH:  return 32'($signed(h));
      LDOP_LHU: return 32'(h);
      default:  return w;
    endcase
  endfunction

  function automatic bit model_misaligned(input rvga_ldop_e op, input logic [1:0] a);
    if (op == LDOP_LH || op == LDOP_LHU) return a[0];
    if (op == LDOP_LW) return a != 2'd0;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    exp_w = 1'b0;
    wb.mem_writeback_v    = 1'b0;
    wb.mem_writeback_ld_v = 1'b0;
    wb.dmem_resp_v        = 1'b0;
    wb.dmem_resp_data     = $urandom;
  endtask

  task automatic exp_reset();
    exp_ready = 1'b1; exp_w = 1'b0; exp_rd = '0; exp_data = '0; exp_instret = '0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_reset();
    step();
    rst = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic wv, input logic [31:0] d, input bit spur);
    wb.mem_writeback_v        = 1'b1;
    wb.mem_writeback_ld_v     = 1'b0;
    wb.mem_writeback_rd       = rd;
    wb.mem_writeback_rd_w_v   = wv;
    wb.mem_writeback_alu_data = d;
    wb.mem_writeback_ldop     = rvga_ldop_e'($urandom_range(0, 4));
    wb.mem_writeback_addr_lo  = 2'($urandom);
    wb.dmem_resp_v            = spur;
    step();
    exp_instret++;
    if (spur) exp_err = 1'b1;
    if (wv && rd != 5'd0) begin
      exp_w = 1'b1; exp_rd = rd; exp_data = d;
    end
  endtask

  // k: stall cycle carrying the response (0 = never); rst_at: stall cycle in which reset hits (0 = none)
  task automatic do_load(input rvga_ldop_e op, input logic [1:0] a, input logic [4:0] rd, input logic wv,
                         input logic [31:0] word, input int k, input bit spur, input int rst_at);
    wb.mem_writeback_v        = 1'b1;
    wb.mem_writeback_ld_v     = 1'b1;
    wb.mem_writeback_rd       = rd;
    wb.mem_writeback_rd_w_v   = wv;
    wb.mem_writeback_alu_data = $urandom;
    wb.mem_writeback_ldop     = op;
    wb.mem_writeback_addr_lo  = a;
    wb.dmem_resp_v            = spur;
    step();
    exp_ready = 1'b0;
    if (spur) exp_err = 1'b1;
    for (int i = 1; i <= timeout_p; i++) begin
      wb.mem_writeback_v        = 1'($urandom_range(0, 1));
      wb.mem_writeback_ld_v     = 1'($urandom_range(0, 1));
      wb.mem_writeback_rd       = 5'($urandom_range(1, 31));
      wb.mem_writeback_rd_w_v   = 1'b1;
      wb.mem_writeback_alu_data = $urandom;
      if (i == rst_at) begin
        do_reset();
        return;
      end
      if (i == k) begin
        wb.dmem_resp_v    = 1'b1;
        wb.dmem_resp_data = word;
      end
      step();
      if (i == k) begin
        exp_ready = 1'b1;
        exp_instret++;
        if (model_misaligned(op, a)) exp_err = 1'b1;
        else if (wv && rd != 5'd0) begin
          exp_w = 1'b1; exp_rd = rd; exp_data = model_fmt(op, a, word);
        end
        return;
      end
    end
    exp_ready = 1'b1;
    exp_err   = 1'b1;
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    int sel;
    wb.mem_writeback_v        = 1'b0;
    wb.mem_writeback_rd       = '0;
    wb.mem_writeback_rd_w_v   = 1'b0;
    wb.mem_writeback_alu_data = '0;
    wb.mem_writeback_ld_v     = 1'b0;
    wb.mem_writeback_ldop     = LDOP_LW;
    wb.mem_writeback_addr_lo  = '0;
    wb.dmem_resp_v            = 1'b0;
    wb.dmem_resp_data         = '0;
    exp_reset();
    step();
    step();
    rst    = 1'b0;
    chk_en = 1'b1;

    check64("lit_reset_ready",   64'(wb.mem_writeback_ready), 64'd1);
    check64("lit_reset_instret", wb.writeback_instret, 64'd0);
    check64("lit_reset_err",     64'(wb.writeback_err), 64'd0);

    do_alu(5'd5, 1'b1, 32'h1234, 1'b0);
    check64("lit_add_w",       64'(wb.writeback_rfetch_rd_w_v), 64'd1);
    check64("lit_add_rd",      64'(wb.writeback_rfetch_rd), 64'd5);
    check64("lit_add_data",    64'(wb.writeback_rfetch_rd_data), 64'h1234);
    check64("lit_add_instret", wb.writeback_instret, 64'd1);

    do_alu(5'd0, 1'b1, 32'hDEAD, 1'b0);
    check64("lit_x0_w",       64'(wb.writeback_rfetch_rd_w_v), 64'd0);
    check64("lit_x0_instret", wb.writeback_instret, 64'd2);

    do_load(LDOP_LB, 2'd3, 5'd7, 1'b1, 32'h80FF_FFFF, 2, 1'b0, 0);
    check64("lit_lb_data", 64'(wb.writeback_rfetch_rd_data), 64'hFFFF_FF80);
    do_load(LDOP_LBU, 2'd3, 5'd7, 1'b1, 32'h80FF_FFFF, 1, 1'b0, 0);
    check64("lit_lbu_data", 64'(wb.writeback_rfetch_rd_data), 64'h0000_0080);
    check64("lit_lbu_err",  64'(wb.writeback_err), 64'd0);

    do_load(LDOP_LH, 2'd1, 5'd8, 1'b1, 32'h1234_5678, 1, 1'b0, 0);
    check64("lit_mis_err",     64'(wb.writeback_err), 64'd1);
    check64("lit_mis_w",       64'(wb.writeback_rfetch_rd_w_v), 64'd0);
    check64("lit_mis_instret", wb.writeback_instret, 64'd5);

    do_reset();
    ready_low_cnt = 0;
    do_load(LDOP_LW, 2'd0, 5'd9, 1'b1, 32'h0, 0, 1'b0, 0);
    check64("lit_to_ready_low", 64'(ready_low_cnt), 64'd4);
    check64("lit_to_ready",     64'(wb.mem_writeback_ready), 64'd1);
    check64("lit_to_err",       64'(wb.writeback_err), 64'd1);
    check64("lit_to_instret",   wb.writeback_instret, 64'd0);

    do_reset();
    do_load(LDOP_LW, 2'd0, 5'd9, 1'b1, 32'hCAFE_F00D, 0, 1'b0, 2);
    wb.dmem_resp_v    = 1'b1;
    wb.dmem_resp_data = 32'hCAFE_F00D;
    step();
    exp_err = 1'b1;
    check64("lit_rst_w",       64'(wb.writeback_rfetch_rd_w_v), 64'd0);
    check64("lit_rst_err",     64'(wb.writeback_err), 64'd1);
    check64("lit_rst_instret", wb.writeback_instret, 64'd0);

    do_reset();
    do_load(LDOP_LW, 2'd0, 5'd3, 1'b1, 32'hA5A5_0001, 1, 1'b1, 0);
    check64("lit_spur_err",  64'(wb.writeback_err), 64'd1);
    check64("lit_spur_data", 64'(wb.writeback_rfetch_rd_data), 64'hA5A5_0001);

    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 8) do_reset();
      else if (sel < 12) begin
        wb.dmem_resp_v = 1'b1;
        step();
        exp_err = 1'b1;
      end else if (sel < 17) step();
      else if (sel < 50) do_alu(rand_rd(), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 19) == 0);
      else do_load(rvga_ldop_e'($urandom_range(0, 4)), 2'($urandom), rand_rd(),
                   1'($urandom_range(0, 3) != 0), $urandom, int'($urandom_range(0, timeout_p)),
                   $urandom_range(0, 19) == 0,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, timeout_p)) : 0);
    end
    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
